// File: rtl/axil_sram_if.sv
// AXI4-Lite-style load/store bus between the core's memory stage and the SRAM responder.
// Valid/ready rule on every channel: a transfer happens on a posedge where both are high; once valid rises, it and its payload hold until that edge.
interface axil_sram_if;
  logic        mem_arvalid;
  logic        mem_arready;
  logic [31:0] mem_araddr;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_awvalid;
  logic        mem_awready;
  logic [31:0] mem_awaddr;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_bvalid;
  logic        mem_bready;
  logic [1:0]  mem_bresp;

  modport master (
    output mem_arvalid, mem_araddr, mem_rready,
    output mem_awvalid, mem_awaddr, mem_wvalid, mem_wdata, mem_wstrb, mem_bready,
    input  mem_arready, mem_rvalid, mem_rdata, mem_rresp,
    input  mem_awready, mem_wready, mem_bvalid, mem_bresp
  );

  modport slave (
    input  mem_arvalid, mem_araddr, mem_rready,
    input  mem_awvalid, mem_awaddr, mem_wvalid, mem_wdata, mem_wstrb, mem_bready,
    output mem_arready, mem_rvalid, mem_rdata, mem_rresp,
    output mem_awready, mem_wready, mem_bvalid, mem_bresp
  );
endinterface

// File: rtl/axil_sram_slave.sv
// Word-array memory responder with independent read and write FSMs, one outstanding transaction per channel.
// Define AXIL_SRAM_RAND_DELAY_EN to add LFSR-driven response delays of 0..31 cycles; otherwise latency is fixed.
module axil_sram_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 12
) (
  input  logic        clk,
  input  logic        rst,
  axil_sram_if.slave  mem,
  output logic [1:0]  rd_state_dbg,
  output logic [1:0]  wr_state_dbg
);
  localparam int          DEPTH = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  logic [31:0] ram [DEPTH];

  logic [4:0] rd_delay, wr_delay;

`ifdef AXIL_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign rd_delay = lfsr[4:0];
  assign wr_delay = lfsr[7:3];
`else
  assign rd_delay = 5'd0;
  assign wr_delay = 5'd0;
`endif

  // ---------------- read channel ----------------
  r_state_t    r_state, r_next;
  logic [31:0] r_addr_q, r_addr_sel;
  logic [4:0]  r_cnt_q;
  logic        r_sample;
  logic [32:0] r_off;

  // A zero delay samples straight from the incoming address so rvalid follows AR by one cycle.
  assign r_addr_sel = (r_state == R_IDLE) ? mem.mem_araddr : r_addr_q;
  assign r_off      = {1'b0, r_addr_sel} - {1'b0, BASE_ADDR};

  always_comb begin
    r_next          = r_state;
    r_sample        = 1'b0;
    mem.mem_arready = 1'b0;
    mem.mem_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        mem.mem_arready = 1'b1;
        if (mem.mem_arvalid) begin
          if (rd_delay == 5'd0) begin
            r_sample = 1'b1;
            r_next   = R_RESP;
          end else begin
            r_next = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt_q == 5'd0) begin
          r_sample = 1'b1;
          r_next   = R_RESP;
        end
      end
      R_RESP: begin
        mem.mem_rvalid = 1'b1;
        if (mem.mem_rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_q      <= '0;
      r_cnt_q       <= '0;
      mem.mem_rdata <= '0;
      mem.mem_rresp <= 2'b00;
    end else begin
      if (r_state == R_IDLE && mem.mem_arvalid) begin
        r_addr_q <= mem.mem_araddr;
        r_cnt_q  <= (rd_delay == 5'd0) ? 5'd0 : rd_delay - 5'd1;
      end else if (r_state == R_WAIT && r_cnt_q != 5'd0) begin
        r_cnt_q <= r_cnt_q - 5'd1;
      end
      if (r_sample) begin
        if (r_off < SPAN) begin
          mem.mem_rdata <= ram[r_off[DEPTH_LOG2+1:2]];
          mem.mem_rresp <= 2'b00;
        end else begin
          mem.mem_rdata <= '0;
          mem.mem_rresp <= 2'b10;
        end
      end
    end
  end

  // ---------------- write channel ----------------
  w_state_t    w_state, w_next;
  logic        aw_held, w_held, aw_fire, w_fire, both_have, w_commit;
  logic [31:0] aw_addr_q, w_data_q, eff_addr, eff_data;
  logic [3:0]  w_strb_q, eff_strb;
  logic [4:0]  w_cnt_q;
  logic [32:0] w_off;
  logic        unused_strb_hi;

  assign unused_strb_hi = &{1'b0, mem.mem_wstrb[7:4]};

  assign aw_fire   = (w_state == W_IDLE) && !aw_held && mem.mem_awvalid;
  assign w_fire    = (w_state == W_IDLE) && !w_held  && mem.mem_wvalid;
  assign both_have = (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
  // Held flags stay set until the B handshake, so the held copies are valid through W_WAIT.
  assign eff_addr  = aw_held ? aw_addr_q : mem.mem_awaddr;
  assign eff_data  = w_held  ? w_data_q  : mem.mem_wdata;
  assign eff_strb  = w_held  ? w_strb_q  : mem.mem_wstrb[3:0];
  assign w_off     = {1'b0, eff_addr} - {1'b0, BASE_ADDR};

  always_comb begin
    w_next          = w_state;
    w_commit        = 1'b0;
    mem.mem_awready = 1'b0;
    mem.mem_wready  = 1'b0;
    mem.mem_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        mem.mem_awready = !aw_held;
        mem.mem_wready  = !w_held;
        if (both_have) begin
          if (wr_delay == 5'd0) begin
            w_commit = 1'b1;
            w_next   = W_RESP;
          end else begin
            w_next = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if (w_cnt_q == 5'd0) begin
          w_commit = 1'b1;
          w_next   = W_RESP;
        end
      end
      W_RESP: begin
        mem.mem_bvalid = 1'b1;
        if (mem.mem_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      w_cnt_q       <= '0;
      mem.mem_bresp <= 2'b00;
    end else begin
      if (aw_fire) begin
        aw_held   <= 1'b1;
        aw_addr_q <= mem.mem_awaddr;
      end
      if (w_fire) begin
        w_held   <= 1'b1;
        w_data_q <= mem.mem_wdata;
        w_strb_q <= mem.mem_wstrb[3:0];
      end
      if (both_have) begin
        w_cnt_q <= (wr_delay == 5'd0) ? 5'd0 : wr_delay - 5'd1;
      end else if (w_state == W_WAIT && w_cnt_q != 5'd0) begin
        w_cnt_q <= w_cnt_q - 5'd1;
      end
      if (w_commit) mem.mem_bresp <= (w_off < SPAN) ? 2'b00 : 2'b10;
      if (w_state == W_RESP && mem.mem_bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  // Contents survive reset; reset only blocks a commit landing on the same edge.
  always_ff @(posedge clk) begin
    if (w_commit && !rst && (w_off < SPAN)) begin
      for (int b = 0; b < 4; b++) begin
        if (eff_strb[b]) ram[w_off[DEPTH_LOG2+1:2]][8*b +: 8] <= eff_data[8*b +: 8];
      end
    end
  end

  assign rd_state_dbg = r_state;
  assign wr_state_dbg = w_state;
endmodule

// File: tb/tb_axil_sram_slave.sv
// Directed bench for axil_sram_slave; with AXIL_SRAM_RAND_DELAY_EN it adds a random scoreboard run against an LFSR delay model.
module tb_axil_sram_slave;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic       clk;
  logic       rst;
  logic [1:0] rd_state_dbg, wr_state_dbg;
  int         n_vec = 0;
  int         n_err = 0;
  logic [31:0] exp_q[$];

  axil_sram_if mem ();

  axil_sram_slave #(.BASE_ADDR(BASE), .DEPTH_LOG2(12)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem          (mem),
    .rd_state_dbg (rd_state_dbg),
    .wr_state_dbg (wr_state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

`ifdef AXIL_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_m;
  always @(posedge clk) begin
    if (rst) lfsr_m <= 8'hA5;
    else     lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end
  function automatic logic [4:0] rd_d_model();
    return lfsr_m[4:0];
  endfunction
  function automatic logic [4:0] wr_d_model();
    return lfsr_m[7:3];
  endfunction
`else
  function automatic logic [4:0] rd_d_model();
    return 5'd0;
  endfunction
  function automatic logic [4:0] wr_d_model();
    return 5'd0;
  endfunction
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input int hold);
    int t;
    int lat;
    logic [4:0]  dexp;
    logic [31:0] exp_d;
    t = 0;
    while (!mem.mem_arready && t < 50) begin @(posedge clk); #1; t++; end
    check("arready_idle", 32'(mem.mem_arready), 32'd1);
    exp_q.push_back(exp_data);
    mem.mem_arvalid = 1'b1;
    mem.mem_araddr  = addr;
    dexp = rd_d_model();
    @(posedge clk); #1;
    mem.mem_arvalid = 1'b0;
    check("arready_lo", 32'(mem.mem_arready), 32'd0);
    lat = 1;
    while (!mem.mem_rvalid && lat < 40) begin @(posedge clk); #1; lat++; end
    check("rd_lat", 32'(lat), 32'(dexp) + 32'd1);
`ifdef AXIL_SRAM_RAND_DELAY_EN
    check("rd_lat_range", 32'(lat >= 1 && lat <= 32), 32'd1);
`endif
    exp_d = exp_q.pop_front();
    for (int i = 0; i <= hold; i++) begin
      mem.mem_rready = 1'b0;
      check("rvalid", 32'(mem.mem_rvalid), 32'd1);
      check("rdata", mem.mem_rdata, exp_d);
      check("rresp", 32'(mem.mem_rresp), 32'(exp_resp));
      if (i < hold) begin @(posedge clk); #1; end
    end
    mem.mem_rready = 1'b1;
    @(posedge clk); #1;
    mem.mem_rready = 1'b0;
    check("rvalid_drop", 32'(mem.mem_rvalid), 32'd0);
    check("arready_back", 32'(mem.mem_arready), 32'd1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] strb,
                          input logic [1:0] exp_resp, input int gap, input int hold);
    int t;
    int lat;
    logic [4:0] dexp;
    t = 0;
    while (!(mem.mem_awready && mem.mem_wready) && t < 50) begin @(posedge clk); #1; t++; end
    check("awready_idle", 32'(mem.mem_awready), 32'd1);
    check("wready_idle", 32'(mem.mem_wready), 32'd1);
    mem.mem_wvalid = 1'b1;
    mem.mem_wdata  = data;
    mem.mem_wstrb  = strb;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
      mem.mem_wvalid = 1'b0;
      if (i == 0) begin
        check("wready_lo_early", 32'(mem.mem_wready), 32'd0);
        check("awready_still_hi", 32'(mem.mem_awready), 32'd1);
      end
    end
    mem.mem_awvalid = 1'b1;
    mem.mem_awaddr  = addr;
    dexp = wr_d_model();
    @(posedge clk); #1;
    mem.mem_awvalid = 1'b0;
    mem.mem_wvalid  = 1'b0;
    lat = 1;
    while (!mem.mem_bvalid && lat < 40) begin @(posedge clk); #1; lat++; end
    check("wr_lat", 32'(lat), 32'(dexp) + 32'd1);
`ifdef AXIL_SRAM_RAND_DELAY_EN
    check("wr_lat_range", 32'(lat >= 1 && lat <= 32), 32'd1);
`endif
    for (int i = 0; i <= hold; i++) begin
      check("bvalid", 32'(mem.mem_bvalid), 32'd1);
      check("bresp", 32'(mem.mem_bresp), 32'(exp_resp));
      if (i < hold) begin @(posedge clk); #1; end
    end
    mem.mem_bready = 1'b1;
    @(posedge clk); #1;
    mem.mem_bready = 1'b0;
    check("bvalid_drop", 32'(mem.mem_bvalid), 32'd0);
    check("awready_back", 32'(mem.mem_awready), 32'd1);
    check("wready_back", 32'(mem.mem_wready), 32'd1);
  endtask

`ifdef AXIL_SRAM_RAND_DELAY_EN
  logic [31:0] model_mem [16];

  task automatic random_run();
    logic [31:0] addr, data, exp_d;
    logic [7:0]  strb;
    logic [1:0]  resp;
    int          w;
    logic        hit;
    for (int k = 0; k < 16; k++) begin
      data = $urandom;
      model_mem[k] = data;
      do_write(BASE + 32'(4 * k), data, 8'h0F, 2'b00, 0, 0);
    end
    for (int n = 0; n < 200; n++) begin
      w   = $urandom_range(0, 15);
      hit = ($urandom_range(0, 9) != 9);
      if (hit) addr = BASE + 32'(4 * w) + 32'($urandom_range(0, 3));
      else     addr = ($urandom_range(0, 1) == 0) ? 32'h7FFF_FFFC : 32'h8000_4000 + 32'(4 * w);
      resp = hit ? 2'b00 : 2'b10;
      if ($urandom_range(0, 1) == 0) begin
        data = $urandom;
        strb = 8'($urandom_range(0, 255));
        if (hit) begin
          for (int b = 0; b < 4; b++)
            if (strb[b]) model_mem[w][8*b +: 8] = data[8*b +: 8];
        end
        do_write(addr, data, strb, resp, $urandom_range(0, 2), $urandom_range(0, 2));
      end else begin
        exp_d = hit ? model_mem[w] : 32'h0;
        do_read(addr, exp_d, resp, $urandom_range(0, 2));
      end
    end
  endtask

  task automatic reset_in_wait();
    logic [4:0] dexp;
    int         done;
    done = 0;
    for (int k = 0; k < 20 && done == 0; k++) begin
      dexp = lfsr_m[4:0];
      mem.mem_arvalid = 1'b1;
      mem.mem_araddr  = BASE;
      @(posedge clk); #1;
      mem.mem_arvalid = 1'b0;
      if (dexp >= 5'd1) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_rvalid", 32'(mem.mem_rvalid), 32'd0);
        check("rst_arready", 32'(mem.mem_arready), 32'd1);
        done = 1;
      end else begin
        mem.mem_rready = 1'b1;
        @(posedge clk); #1;
        mem.mem_rready = 1'b0;
      end
    end
    check("rst_test_ran", 32'(done), 32'd1);
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    mem.mem_arvalid = 1'b0; mem.mem_araddr = '0; mem.mem_rready = 1'b0;
    mem.mem_awvalid = 1'b0; mem.mem_awaddr = '0;
    mem.mem_wvalid  = 1'b0; mem.mem_wdata  = '0; mem.mem_wstrb = '0;
    mem.mem_bready  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_arready", 32'(mem.mem_arready), 32'd1);
    check("rst_awready", 32'(mem.mem_awready), 32'd1);
    check("rst_wready", 32'(mem.mem_wready), 32'd1);
    check("rst_rvalid", 32'(mem.mem_rvalid), 32'd0);
    check("rst_bvalid", 32'(mem.mem_bvalid), 32'd0);
    check("rst_rdata", mem.mem_rdata, 32'h0);
    check("rst_rresp", 32'(mem.mem_rresp), 32'd0);
    check("rst_bresp", 32'(mem.mem_bresp), 32'd0);

    // basic write then read
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 2'b00, 0, 0);
    do_read (32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 0);

    // byte enables; upper strobe bits are ignored
    do_write(32'h8000_0020, 32'h1122_3344, 8'h0F, 2'b00, 0, 0);
    do_write(32'h8000_0020, 32'hAABB_CCDD, 8'h05, 2'b00, 0, 0);
    do_read (32'h8000_0020, 32'h11BB_33DD, 2'b00, 0);
    do_write(32'h8000_0020, 32'hFFFF_FFFF, 8'hF0, 2'b00, 0, 0);
    do_read (32'h8000_0020, 32'h11BB_33DD, 2'b00, 0);

    // W three cycles ahead of AW, responses back-pressured for four cycles
    do_write(32'h8000_0030, 32'h0BAD_F00D, 8'h0F, 2'b00, 3, 4);
    do_read (32'h8000_0030, 32'h0BAD_F00D, 2'b00, 4);

    // range boundaries and ignored low address bits
    do_write(32'h8000_0000, 32'h1357_9BDF, 8'h0F, 2'b00, 0, 0);
    do_read (32'h7FFF_FFFC, 32'h0, 2'b10, 0);
    do_write(32'h8000_4000, 32'hFFFF_FFFF, 8'h0F, 2'b10, 0, 0);
    do_read (32'h8000_0000, 32'h1357_9BDF, 2'b00, 0);
    do_read (32'h8000_0003, 32'h1357_9BDF, 2'b00, 0);
    do_write(32'h8000_3FFC, 32'hCAFE_0001, 8'h0F, 2'b00, 0, 0);
    do_read (32'h8000_3FFC, 32'hCAFE_0001, 2'b00, 0);

`ifndef AXIL_SRAM_RAND_DELAY_EN
    // read sample and write commit on the same edge: read sees old data
    do_write(32'h8000_0014, 32'h0, 8'h0F, 2'b00, 0, 0);
    fork
      do_read (32'h8000_0014, 32'h0, 2'b00, 0);
      do_write(32'h8000_0014, 32'h1234_5678, 8'h0F, 2'b00, 0, 0);
    join
    do_read(32'h8000_0014, 32'h1234_5678, 2'b00, 0);
`else
    random_run();
    reset_in_wait();
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axil_sram_slave.md
# axil_sram_slave

- AXI4-Lite-style memory responder: the slave end of the load/store channels driven by the multicycle core's write-back/memory stage.
- Accepts read and write requests on independent channels, stores data in an internal word array, and returns R and B responses.
- With random-latency mode compiled in, responses are delayed by a pseudo-random number of cycles to stress the initiator's handshakes.
- Sits between the WBU memory port and the simulation top; replaces direct combinational memory access.

## Interface
Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of word 0
- DEPTH_LOG2, 12, array holds 2**DEPTH_LOG2 32-bit words

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous active-high reset
- mem_arvalid  in  1  read address valid
- mem_arready  out  1  read address ready
- mem_araddr  in  32  read byte address
- mem_rvalid  out  1  read data valid
- mem_rready  in  1  read data ready
- mem_rdata  out  32  read data
- mem_rresp  out  2  00 OKAY, 10 SLVERR
- mem_awvalid  in  1  write address valid
- mem_awready  out  1  write address ready
- mem_awaddr  in  32  write byte address
- mem_wvalid  in  1  write data valid
- mem_wready  out  1  write data ready
- mem_wdata  in  32  write data
- mem_wstrb  in  8  byte enables; [3:0] used, [7:4] ignored
- mem_bvalid  out  1  write response valid
- mem_bready  in  1  write response ready
- mem_bresp  out  2  00 OKAY, 10 SLVERR

## Operation
- Address decode: offset = addr - BASE_ADDR. In range iff offset < 4 * 2**DEPTH_LOG2. Word index = offset[DEPTH_LOG2+1:2]; addr[1:0] ignored.
- Read FSM:
  - R_IDLE: arready=1. On arvalid, capture araddr and delay d, go to R_WAIT.
  - R_WAIT: count down d. At 0, sample array (or flag error), go to R_RESP.
  - R_RESP: rvalid=1, rdata/rresp stable. On rready, go to R_IDLE.
- Write FSM:
  - W_IDLE: awready=1 until AW is captured; wready=1 until W is captured. AW and W may arrive in either order or in the same cycle. Once both are held, capture d and go to W_WAIT.
  - W_WAIT: count down d. At 0, commit bytes selected by wstrb[3:0] if in range, go to W_RESP.
  - W_RESP: bvalid=1. On bready, go to W_IDLE.
- Out-of-range requests:
  - Read: rresp=10, rdata=0.
  - Write: bresp=10, array unchanged.
- Write commit and read sample in the same cycle at the same word: the read returns the pre-write data.
- Read and write FSMs are fully independent; neither ever stalls the other.
- Array contents are not cleared by reset.

## Timing
- Reset values: arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=00, bresp=00. Both FSMs in IDLE, counters 0.
- rst asserted mid-transaction aborts it: a pending write is not committed, and any outstanding response is dropped next cycle.
- Read latency: AR handshake at cycle T → rvalid high from T+1+d.
- Write latency: the later of the AW/W handshakes at cycle T → commit at posedge ending cycle T+d → bvalid high from T+1+d.
- Ready de-asserts the cycle after capture and re-asserts the cycle after the R or B handshake. There is no back-to-back acceptance, so each channel has at most one outstanding transaction.
- rvalid/bvalid, once high, hold with stable data/resp until the handshake cycle. Dropping valid without ready is illegal.
- Arithmetic: delay counter 5 bits. The offset compare is done in 33 bits so that addr < BASE_ADDR wraps to out-of-range, never aliases.

## Configuration
- AXIL_SRAM_RAND_DELAY_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances every cycle.
  - Read d = lfsr[4:0] sampled at AR capture; write d = lfsr[7:3] sampled when AW and W are both held.
  - d ranges 0..31.
- Undefined: d = 0 for both channels (fixed one-cycle latency). The LFSR is not instantiated.

## Test plan
- Macro off. Write addr 8000_0010, data DEADBEEF, wstrb F, AW and W in the same cycle T → bvalid at T+1, bresp 00. Then read 8000_0010 → rvalid one cycle after AR, rdata DEADBEEF.
- Partial write: word holds 11223344. Write data AABBCCDD with wstrb 5 → read returns 11BB33DD. wstrb[7:4]=F with [3:0]=0 leaves the word unchanged.
- W arrives 3 cycles before AW: wready low after W capture, awready still high. bvalid at AW handshake +1. rready/bready held low 4 cycles → valid and data stay stable.
- Out of range: read 7FFF_FFFC → rresp 10, rdata 0. Write 8000_4000 (DEPTH_LOG2=12) → bresp 10, and word 0 is unchanged on readback.
- Same-cycle collision with macro off: read and write to word 5 (old 0, new 12345678) with AR and final AW/W at the same T → read returns 0; a subsequent read returns 12345678.
- Macro on: 200 random reads and writes checked against a scoreboard. Every observed latency falls in 1..32, the delay sequence matches the LFSR model from seed A5, and rst pulsed during R_WAIT leaves rvalid 0 with arready 1 the next cycle.
